// File: rtl/regfile_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_writeback_arbiter
//
// Shares the single register-file write port between the ALU writeback path
// and the load (memory) writeback path, and keeps a 32-entry scoreboard of
// architectural registers that have writes in flight.
//
// Arbitration: valid/ready handshake on both sources. A lone requester is
// granted immediately. When both request, the source that did not win last
// time is granted (round-robin). The last winner resets to MEM, so ALU wins
// the first contention. Ready is combinational from valid and arbiter state.
//
// Writeback: the granted request is registered onto write_address/write_data
// one cycle later. write_enable is raised only for non-zero destinations;
// x0 grants complete the handshake but issue no write.
//
// Scoreboard: issue_valid marks the destination busy, a committing write
// clears it. When both hit the same register in one cycle the set wins,
// because the issue belongs to a newer instruction. Entry 0 is always clear.
//
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   alu_valid/address/data, alu_ready   ALU writeback handshake
//   mem_valid/address/data, mem_ready   load writeback handshake
//   issue_valid, issue_address     mark a destination busy
//   query_address_1/2, query_busy_1/2   combinational hazard queries
//   write_enable/address/data      registered register-file write port
//   idle                           no busy entries and no write in flight
//
// Optional feature macro WB_BYPASS_EN: adds query_bypass_valid_1/2 and
// query_bypass_data_1/2, forwarding the in-flight write to decode. A query
// that hits the in-flight write reports not-busy so decode forwards instead
// of stalling.
// -----------------------------------------------------------------------------
module regfile_writeback_arbiter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_address,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_address,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_address,
    input  logic [4:0]  query_address_1,
    input  logic [4:0]  query_address_2,
    output logic        query_busy_1,
    output logic        query_busy_2,
    output logic        write_enable,
    output logic [4:0]  write_address,
    output logic [31:0] write_data,
    output logic        idle
`ifdef WB_BYPASS_EN
    ,
    output logic        query_bypass_valid_1,
    output logic        query_bypass_valid_2,
    output logic [31:0] query_bypass_data_1,
    output logic [31:0] query_bypass_data_2
`endif
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e      r_last_grant;
    grant_e      w_last_grant_next;
    logic        w_grant_alu;
    logic        w_grant_mem;
    logic [4:0]  w_grant_address;
    logic [31:0] w_grant_data;

    logic        r_write_enable;
    logic [4:0]  r_write_address;
    logic [31:0] r_write_data;

    logic [31:0] r_busy;
    logic [31:0] w_busy_next;

    logic        w_bypass_hit_1;
    logic        w_bypass_hit_2;

    // Arbiter state register: remembers which source won most recently.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= GRANT_MEM;
        end else begin
            r_last_grant <= w_last_grant_next;
        end
    end

    // Grant selection and next arbiter state.
    always_comb begin
        w_grant_alu       = 1'b0;
        w_grant_mem       = 1'b0;
        w_last_grant_next = r_last_grant;
        if (alu_valid && mem_valid) begin
            case (r_last_grant)
                GRANT_MEM: w_grant_alu = 1'b1;
                GRANT_ALU: w_grant_mem = 1'b1;
                default:   w_grant_alu = 1'b1;
            endcase
        end else if (alu_valid) begin
            w_grant_alu = 1'b1;
        end else if (mem_valid) begin
            w_grant_mem = 1'b1;
        end else begin
            w_grant_alu = 1'b0;
        end

        if (w_grant_alu) begin
            w_last_grant_next = GRANT_ALU;
        end else if (w_grant_mem) begin
            w_last_grant_next = GRANT_MEM;
        end else begin
            w_last_grant_next = r_last_grant;
        end
    end

    assign alu_ready       = w_grant_alu;
    assign mem_ready       = w_grant_mem;
    assign w_grant_address = w_grant_alu ? alu_address : mem_address;
    assign w_grant_data    = w_grant_alu ? alu_data    : mem_data;

    // Register-file write port: capture the granted request for one cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_write_enable  <= 1'b0;
            r_write_address <= 5'd0;
            r_write_data    <= 32'd0;
        end else if (w_grant_alu || w_grant_mem) begin
            r_write_enable  <= (w_grant_address != 5'd0);
            r_write_address <= w_grant_address;
            r_write_data    <= w_grant_data;
        end else begin
            r_write_enable  <= 1'b0;
        end
    end

    // Scoreboard next state: clear on commit first so a same-cycle issue wins.
    always_comb begin
        w_busy_next = r_busy;
        if (r_write_enable) begin
            w_busy_next[r_write_address] = 1'b0;
        end else begin
            w_busy_next = r_busy;
        end
        if (issue_valid && (issue_address != 5'd0)) begin
            w_busy_next[issue_address] = 1'b1;
        end else begin
            w_busy_next[0] = 1'b0;
        end
        w_busy_next[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 32'd0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

`ifdef WB_BYPASS_EN
    assign w_bypass_hit_1 = r_write_enable && (r_write_address == query_address_1)
                            && (query_address_1 != 5'd0);
    assign w_bypass_hit_2 = r_write_enable && (r_write_address == query_address_2)
                            && (query_address_2 != 5'd0);
    assign query_bypass_valid_1 = w_bypass_hit_1;
    assign query_bypass_valid_2 = w_bypass_hit_2;
    assign query_bypass_data_1  = r_write_data;
    assign query_bypass_data_2  = r_write_data;
`else
    assign w_bypass_hit_1 = 1'b0;
    assign w_bypass_hit_2 = 1'b0;
`endif

    // Entry 0 is held clear, so a query of x0 always reports not busy.
    assign query_busy_1  = r_busy[query_address_1] && !w_bypass_hit_1;
    assign query_busy_2  = r_busy[query_address_2] && !w_bypass_hit_2;

    assign write_enable  = r_write_enable;
    assign write_address = r_write_address;
    assign write_data    = r_write_data;
    assign idle          = (r_busy == 32'd0) && !r_write_enable;

endmodule

// File: doc/regfile_writeback_arbiter.md
# regfile_writeback_arbiter

Shares the single register-file write port between the ALU writeback path and the memory (load) writeback path, and tracks which architectural registers have writes in flight. Each writeback source uses a valid/ready handshake, and sources alternate round-robin when both request. Accepted writes are driven as registered write_enable/write_address/write_data toward the register file. A 32-entry busy scoreboard is set by the issue stage and cleared on commit, and it answers two combinational hazard queries for the decode stage.

## Interface
- No parameters; widths fixed (32 registers, 32-bit data).
- clock  input  1  rising-edge clock for all state
- reset_n  input  1  asynchronous, active-low reset
- alu_valid  input  1  ALU writeback request
- alu_address  input  5  ALU destination register
- alu_data  input  32  ALU result
- alu_ready  output  1  ALU request accepted this cycle
- mem_valid  input  1  load writeback request
- mem_address  input  5  load destination register
- mem_data  input  32  load data
- mem_ready  output  1  load request accepted this cycle
- issue_valid  input  1  instruction issued with a destination register
- issue_address  input  5  destination to mark busy
- query_address_1  input  5  hazard query port 1
- query_address_2  input  5  hazard query port 2
- query_busy_1  output  1  query 1 register has a pending write
- query_busy_2  output  1  query 2 register has a pending write
- write_enable  output  1  register-file write strobe (registered)
- write_address  output  5  register-file write address (registered)
- write_data  output  32  register-file write data (registered)
- idle  output  1  no busy bits set and write_enable low

## Operation
- Requester rules: valid, address and data are held stable until ready is seen high. Ready is combinational from valid and arbiter state. Ready never rises without the matching valid.
- Arbiter state last_grant ∈ {ALU, MEM}; resets to MEM, so ALU wins the first contention.
- Only ALU valid: grant ALU. Only MEM valid: grant MEM.
- Both valid: grant the requester that is not last_grant. last_grant updates on every grant.
- At most one grant per cycle. The losing requester's ready stays 0.
- Granted request registers onto write_address/write_data. write_enable is set to 1 only if the granted address != 0.
- Grants to x0 still complete the handshake, but no write is issued and no busy bit changes.
- Scoreboard busy[31:0]:
  - issue_valid with issue_address != 0 sets busy[issue_address].
  - A committing write (write_enable=1) clears busy[write_address].
  - If set and clear target the same register in the same cycle, set wins (a newer write is pending).
  - busy[0] is constant 0.
- query_busy_n = busy[query_address_n], combinational. Address 0 always returns 0.

## Timing
- Reset values: write_enable=0, write_address=0, write_data=0, busy=0, last_grant=MEM, idle=1. alu_ready/mem_ready are 0 while valids are 0.
- Handshake in cycle N → write_enable/write_address/write_data valid in cycle N+1. The register file commits at the edge ending N+1.
- busy clears at the edge ending N+1, the same edge the register file commits. query_busy drops in N+2.
- Back-to-back grants are sustained: throughput is one write per cycle with no bubble.
- Reset assertion mid-operation immediately clears all outputs and state. In-flight writes are dropped, with no partial commit after reset deasserts.
- Issue and commit of different registers in the same cycle are independent.

## Configuration
- WB_BYPASS_EN defined: adds outputs query_bypass_valid_1/2 (1 bit) and query_bypass_data_1/2 (32 bits).
  - query_bypass_valid_n = write_enable && write_address == query_address_n && query_address_n != 0.
  - query_bypass_data_n = write_data.
  - query_busy_n is forced to 0 when the matching bypass is valid, so decode takes the forwarded value instead of stalling.
- WB_BYPASS_EN undefined: bypass ports are absent. query_busy reflects the raw scoreboard, and decode stalls until the busy bit clears.

## Test plan
- Reset: after reset_n pulses low, all outputs are 0 except idle=1, and query_busy_1/2=0 for every address.
- Single ALU write: issue x5, then alu_valid, alu_address=5, alu_data=0xDEADBEEF.
  - alu_ready=1 in the same cycle.
  - Next cycle: write_enable=1, write_address=5, write_data=0xDEADBEEF.
  - query_busy for x5 is 1 until the cycle after that, then 0.
- Contention: both valids held for 4 cycles (ALU→x1, MEM→x2).
  - Grants alternate ALU, MEM, ALU, MEM.
  - write_address sequence is 1, 2, 1, 2 with no idle cycles.
- x0 target: mem_valid with mem_address=0 → mem_ready=1, write_enable stays 0, busy unchanged.
- Set/clear collision: x7 commits in the same cycle issue_valid re-marks x7 → busy[7] remains 1 (query_busy=1).
- WB_BYPASS_EN build: query_address_1=9 while write_enable=1 for x9, write_data=0x12345678 → query_bypass_valid_1=1, query_bypass_data_1=0x12345678, query_busy_1=0.
